// File: rtl/hit_manager.sv
// rtl/hit_manager.sv - player/obstacle collision detection, lives, invulnerability and score
module hit_manager #(
    parameter int PLAYER_X   = 100,
    parameter int PLAYER_W   = 32,
    parameter int PLAYER_H   = 32,
    parameter int OBS_W      = 40,
    parameter int LANE_H     = 120,
    parameter int LIVES      = 3,
    parameter int INV_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  player_y,
    input  logic [9:0]  obs1_x,
    input  logic [9:0]  obs2_x,
    input  logic [1:0]  obs1_pos,
    input  logic [1:0]  obs2_pos,
    input  logic [1:0]  type1,
    input  logic [1:0]  type2,
    input  logic        flick1,
    input  logic        flick2,
    output logic        hit,
    output logic [1:0]  lives,
    output logic        invuln,
    output logic        game_over,
    output logic [15:0] score,
    output logic [1:0]  state
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_PLAY   = 2'b01,
        S_INVULN = 2'b10,
        S_OVER   = 2'b11
    } state_t;

    localparam int INV_W = (INV_CYCLES > 1) ? $clog2(INV_CYCLES) : 1;

    state_t           state_q, state_n;
    logic [INV_W-1:0] inv_cnt, inv_cnt_n;
    logic [1:0]       lives_n;
    logic [15:0]      score_n;
    logic             hit_n;
    logic             collide_q;
    logic [9:0]       prev1_x, prev2_x;
    logic             danger1, danger2;
    logic             wrap1, wrap2;
    logic [16:0]      score_sum;
    logic [15:0]      score_sat;

    // Widened to 11 bits so the right/bottom edge sums never truncate.
    function automatic logic dangerous(input logic [9:0] ox, input logic [1:0] pos,
                                       input logic [1:0] typ, input logic flk,
                                       input logic [9:0] py);
        logic [10:0] x0, y0, top;
        logic        xo, yo;
        x0  = {1'b0, ox};
        y0  = {1'b0, py};
        top = 11'(pos) * 11'(LANE_H);
        xo  = (x0 <= 11'(PLAYER_X + PLAYER_W - 1)) && ((x0 + 11'(OBS_W - 1)) >= 11'(PLAYER_X));
        yo  = (y0 <= (top + 11'(LANE_H - 1))) && ((y0 + 11'(PLAYER_H - 1)) >= top);
        case (typ)
            2'b10:   dangerous = xo && yo && flk;
            2'b11:   dangerous = 1'b0;
            default: dangerous = xo && yo;
        endcase
    endfunction

    assign danger1   = dangerous(obs1_x, obs1_pos, type1, flick1, player_y);
    assign danger2   = dangerous(obs2_x, obs2_pos, type2, flick2, player_y);
    assign wrap1     = (prev1_x == 10'd0) && (obs1_x != 10'd0);
    assign wrap2     = (prev2_x == 10'd0) && (obs2_x != 10'd0);
    assign score_sum = {1'b0, score} + {16'd0, wrap1} + {16'd0, wrap2};
    assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    always_comb begin
        state_n   = state_q;
        lives_n   = lives;
        score_n   = score;
        inv_cnt_n = inv_cnt;
        hit_n     = 1'b0;
        if (state_q == S_PLAY || state_q == S_INVULN)
            score_n = score_sat;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n = S_PLAY;
                    lives_n = 2'(LIVES);
                    score_n = '0;
                end
            end
            S_PLAY: begin
                if (collide_q) begin
                    hit_n   = 1'b1;
                    lives_n = lives - 2'd1;
                    if (lives == 2'd1) begin
                        state_n = S_OVER;
                    end else begin
                        state_n   = S_INVULN;
                        inv_cnt_n = INV_W'(INV_CYCLES - 1);
                    end
                end
            end
            S_INVULN: begin
                if (inv_cnt == '0)
                    state_n = S_PLAY;
                else
                    inv_cnt_n = inv_cnt - INV_W'(1);
            end
            default: begin
                lives_n = 2'd0;
                if (start) begin
                    state_n = S_PLAY;
                    lives_n = 2'(LIVES);
                    score_n = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            lives     <= 2'(LIVES);
            score     <= '0;
            hit       <= 1'b0;
            collide_q <= 1'b0;
            inv_cnt   <= '0;
            prev1_x   <= 10'd1;
            prev2_x   <= 10'd1;
        end else begin
            state_q   <= state_n;
            lives     <= lives_n;
            score     <= score_n;
            hit       <= hit_n;
            collide_q <= danger1 | danger2;
            inv_cnt   <= inv_cnt_n;
            prev1_x   <= obs1_x;
            prev2_x   <= obs2_x;
        end
    end

    // Decoded from the registered state so the renderer sees clean levels.
    assign invuln    = (state_q == S_INVULN);
    assign game_over = (state_q == S_OVER);
    assign state     = state_q;

endmodule
